// File: rtl/mips_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A, B, ALUOut, 32x32 register file and ALU,
// steered cycle by cycle by the control unit's strobes over one unified memory port.
module mips_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCEn,
    input  logic        IorD,
    input  logic        IRWrite,
    input  logic        RegWrite,
    input  logic        RegDst,
    input  logic        MemtoReg,
    input  logic        ALUSrcA,
    input  logic [1:0]  PCSource,
    input  logic [1:0]  ALUSrcB,
    input  logic [2:0]  ALUSel,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [5:0]  opcode,
    output logic [5:0]  func,
    output logic        zero,
    output logic [31:0] pc
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q;
    logic [31:0] mdr_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] aluout_q;
    logic [31:0] regs_q [0:31];

    logic [4:0]  rs_addr, rt_addr, wr_addr;
    logic [31:0] rs_data, rt_data, wr_data;
    logic [31:0] imm_sext;
    logic [31:0] src_a, src_b;
    logic [31:0] alu_result;

    assign rs_addr  = ir_q[25:21];
    assign rt_addr  = ir_q[20:16];
    assign wr_addr  = RegDst ? ir_q[15:11] : ir_q[20:16];
    assign wr_data  = MemtoReg ? mdr_q : aluout_q;
    assign rs_data  = (rs_addr == 5'd0) ? 32'd0 : regs_q[rs_addr];
    assign rt_data  = (rt_addr == 5'd0) ? 32'd0 : regs_q[rt_addr];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

    assign src_a = ALUSrcA ? a_q : pc_q;

    always_comb begin
        src_b = b_q;
        case (ALUSrcB)
            2'b00: src_b = b_q;
            2'b01: src_b = 32'd4;
            2'b10: src_b = imm_sext;
            2'b11: src_b = {imm_sext[29:0], 2'b00};
            default: src_b = b_q;
        endcase
    end

    always_comb begin
        alu_result = 32'd0;
        case (ALUSel)
            3'b000: alu_result = src_a & src_b;
            3'b001: alu_result = src_a | src_b;
            3'b010: alu_result = src_a + src_b;
            3'b110: alu_result = src_a - src_b;
            3'b111: alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
            3'b011: alu_result = src_b >> src_a[4:0];
            default: alu_result = 32'd0;
        endcase
    end

    // PCSource 11 feeds the current PC back, so PCEn with 11 is a hold.
    always_comb begin
        pc_d = pc_q;
        case (PCSource)
            2'b00: pc_d = alu_result;
            2'b01: pc_d = aluout_q;
            2'b10: pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
            2'b11: pc_d = pc_q;
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            ir_q     <= 32'd0;
            mdr_q    <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            aluout_q <= 32'd0;
        end else begin
            if (PCEn) begin
                pc_q <= pc_d;
            end
            if (IRWrite) begin
                ir_q <= mem_rdata;
            end
            mdr_q    <= mem_rdata;
            a_q      <= rs_data;
            b_q      <= rt_data;
            aluout_q <= alu_result;
        end
    end

    // No write-to-read bypass: A/B capture the pre-edge contents on a write edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (RegWrite && (wr_addr != 5'd0)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    assign mem_addr  = IorD ? aluout_q : pc_q;
    assign mem_wdata = b_q;
    assign opcode    = ir_q[31:26];
    assign func      = ir_q[5:0];
    assign zero      = (alu_result == 32'd0);
    assign pc        = pc_q;

endmodule

// File: doc/mips_datapath.md
# mips_datapath

Multicycle MIPS datapath that sits directly downstream of the control unit. It consumes every control strobe the controller produces: PCEn, IorD, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource and ALUSel. It returns opcode, func and zero to the controller, closing the loop. It holds PC, IR, MDR, A, B and ALUOut, a 32x32 register file and the ALU, and drives a single unified external memory port.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; clears all state immediately while low.
- PCEn, IorD, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA  in  1 each  control strobes from the control unit.
- PCSource, ALUSrcB  in  2 each  mux selects from the control unit.
- ALUSel  in  3  ALU operation select.
- mem_rdata  in  32  memory read data; combinational, valid in the same cycle as mem_addr.
- mem_addr  out  32  memory address, defined as IorD ? ALUOut : PC.
- mem_wdata  out  32  memory write data, equal to B. MemRead and MemWrite go straight from the controller to memory.
- opcode  out  6  IR[31:26].
- func  out  6  IR[5:0].
- zero  out  1  combinational; set when the ALU result equals 0.
- pc  out  32  current PC, for debug.

## Operation
- SrcA: ALUSrcA=0 selects PC; ALUSrcA=1 selects A.
- SrcB selected by ALUSrcB:
  - 00: B.
  - 01: 32'd4.
  - 10: sign-extended IR[15:0].
  - 11: sign-extended IR[15:0] << 2.
- ALU operations selected by ALUSel:
  - 000: AND.
  - 001: OR.
  - 010: ADD, wrapping mod 2^32.
  - 110: SUB (SrcA−SrcB), wrapping.
  - 111: SLT, signed; result is 1 or 0.
  - 011: SRLV, result SrcB >> SrcA[4:0], logical.
  - All other codes: result 0.
- Register file:
  - Read ports are combinational on IR[25:21] (rs) and IR[20:16] (rt).
  - Reading register 0 always returns 0.
  - Write address is RegDst ? IR[15:11] : IR[20:16].
  - Write data is MemtoReg ? MDR : ALUOut.
  - Writes to register 0 are discarded.
- Next PC, selected by PCSource:
  - 00: ALU result.
  - 01: ALUOut.
  - 10: {PC[31:28], IR[25:0], 2'b00}.
  - 11: PC, i.e. hold.
- PC loads the next-PC value only when PCEn=1.

## Timing
- Reset (rst=0): PC=RESET_PC; IR, MDR, A, B, ALUOut and all 32 registers are 0.
  - Resulting outputs: opcode=0, func=0, mem_addr=RESET_PC, mem_wdata=0, pc=RESET_PC.
  - zero follows the ALU; with all strobes low it equals (PC & B)==0.
- Reset asserted mid-instruction aborts the instruction asynchronously. No partial register-file write may complete on that edge.
- Per rising edge, with rst high:
  - IR ← mem_rdata if IRWrite.
  - MDR ← mem_rdata, unconditionally.
  - A ← rs data and B ← rt data, unconditionally.
  - ALUOut ← ALU result, unconditionally.
  - Register file written if RegWrite.
  - PC updated if PCEn.
- No read/write bypass: a register written on edge N reads the new value only after edge N.
- A and B latch the values read before that write.
- IRWrite and PCEn in the same cycle is legal. IR captures the word at the old PC, because mem_addr uses the pre-edge PC.
- Branch-taken decisions (PCWriteCond & zero) are formed in the controller from the combinational zero output. The datapath only honours PCEn.
- Latency: the datapath itself adds none. Each multicycle step is one clock.

## Test plan
- Reset: hold rst=0 with random strobes. Required: pc=RESET_PC, opcode=0, all registers 0. Pulse rst low mid-instruction: all state clears without waiting for a clock edge.
- Fetch: PC=0, mem_rdata=32'h0109_5020 (add $10,$8,$9), IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUSel=010, PCSource=00, PCEn=1. After one edge: pc=4, opcode=0, func=6'h20.
- R-type add with $8=5 and $9=7:
  - Decode cycle, then execute with ALUSrcA=1, ALUSrcB=00, ALUSel=010.
  - Writeback with RegDst=1, MemtoReg=0, RegWrite=1.
  - Required: $10=12. A second add into $0 leaves $0 reading 0.
- SRLV and SLT:
  - $8=3, $9=32'h8000_0000, ALUSel=011: ALUOut=32'h1000_0000.
  - ALUSel=111 with A=−1, B=1: ALUOut=1.
  - SUB 5−5: zero=1.
- lw/sw with A=32'h100 and imm=16'hFFFC:
  - ALUSrcB=10 gives ALUOut=32'hFC.
  - IorD=1 gives mem_addr=32'hFC.
  - mem_rdata=32'hDEAD_BEEF, MemtoReg=1, RegDst=0, RegWrite=1: rt=32'hDEAD_BEEF.
  - For sw, mem_wdata=B.
- Branch and jump with PC=32'h40:
  - imm=3 and ALUSrcB=11 gives ALUOut=32'h4C.
  - PCSource=01 with PCEn=1 gives pc=32'h4C.
  - j with IR[25:0]=26'h10 and PCSource=10 gives pc=32'h40.
  - PCSource=11 holds pc.
